uart_rx_core: RTL

//  UART receiver: the downstream partner of the serial transmitter. It consumes the tx line and

---
 rtl/uart_rx_core.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver, start + 8 data (LSB first) + odd parity + 1 stop.
// Ports: clk, rst (sync, high), rx in; rx_data, data_strobe, parity_error, framing_error, rx_busy out.
module uart_rx_core #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 19_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CNT_W      = $clog2(BIT_CYCLES);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bit;

  // Idle-high line: sync flops reset to 1 so reset never
  // fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      rx_data       <= 8'h00;
      data_strobe   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      data_strobe   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end

        // Recheck at mid start bit to reject glitches.
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= S_PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data      <= shreg;
              data_strobe  <= 1'b1;
              parity_error <= ~^{shreg, par_bit};
              state        <= S_IDLE;
              rx_busy      <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              state         <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Line held low after a bad stop: wait for idle.
        S_BREAK: begin
          if (rx_s) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
